cpu_boot_ctrl: RTL and testbench
================================

// Module: cpu_boot_ctrl
// PURPOSE
//  Boot/run sequencer for CPU. Streams a program into the instruction cache over a
//  valid/ready port, then zero-fills the unloaded words. Holds the core in reset while
//  loading, releases it to run, counts run cycles and parks the core on halt.
//  Sits between the host/loader and CPU (icache write port, core reset, run enable).
// PARAMETERS
//  ADDR_W      5    icache word-address width; DEPTH = 2**ADDR_W words (32)
//  DATA_W      32   instruction word width
//  MAX_CYCLES  5000 watchdog run-cycle limit (used only with CYCLE_LIMIT_EN)
// PORTS
//  CLOCK_50      in   1       system clock, rising edge
//  RESET         in   1       asynchronous reset, active-high
//  start_load    in   1       1-cycle pulse: begin load (accepted in IDLE or HALT only)
//  load_valid    in   1       loader word valid
//  load_data     in   DATA_W  loader word
//  load_last     in   1       qualifies final word of program
//  load_ready    out  1       block accepts a word this cycle
//  icache_we     out  1       icache write strobe
//  icache_addr   out  ADDR_W  icache write address
//  icache_wdata  out  DATA_W  icache write data
//  cpu_rst       out  1       core reset, active-high
//  cpu_run       out  1       core clock-enable
//  halt_req      in   1       core reports halt
//  run_cycles    out  32      cycles spent in RUN, saturating
//  done          out  1       core parked (HALT state)
//  timeout       out  1       halt caused by watchdog
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, icache_we=0, icache_addr=0, icache_wdata=0,
//   cpu_rst=1, cpu_run=0, load_ready=0, run_cycles=0, done=0, timeout=0. Partial loads discarded.
//  States: IDLE, LOAD, FILL, RUN, HALT; outputs registered from state.
//  IDLE: cpu_rst=1. start_load -> LOAD, write pointer wp=0.
//  LOAD: load_ready=1. Handshake = load_valid & load_ready. Handshake in cycle N ->
//   icache_we=1, icache_addr=wp, icache_wdata=load_data in cycle N+1; wp++.
//   Handshake with load_last=1 or wp==DEPTH-1: load_ready drops in cycle N+1;
//   if wp==DEPTH-1 -> RUN, else -> FILL (last word overrides remaining capacity).
//  FILL: load_ready=0; one zero word/cycle at wp..DEPTH-1 (icache_we=1, wdata=0);
//   after writing DEPTH-1 -> RUN. wp wraps to 0 only on entry to LOAD.
//  RUN: entry cycle cpu_rst=0, cpu_run=1, run_cycles cleared to 0 then +1 per RUN cycle,
//   saturates at 2**32-1. halt_req=1 -> HALT next cycle; cpu_run=0 that cycle.
//  HALT: cpu_run=0, cpu_rst=0 (regs stay readable), done=1. start_load -> LOAD,
//   cpu_rst=1, done=0, timeout=0; run_cycles held until next RUN entry.
//  start_load in LOAD/FILL/RUN ignored. halt_req outside RUN ignored.
//  load_valid while load_ready=0: no write, data not sampled. icache_we never high outside LOAD/FILL.
// CONFIGURATION
//  CYCLE_LIMIT_EN defined: in RUN, when run_cycles reaches MAX_CYCLES with no halt_req ->
//   HALT next cycle with timeout=1; halt_req in that same cycle wins (timeout=0).
//  CYCLE_LIMIT_EN undefined: no watchdog, RUN exits only on halt_req or RESET; timeout tied 0.
// TESTING
//  Reset released, no stimulus -> cpu_rst=1, cpu_run=0, done=0, icache_we=0 indefinitely.
//  start_load, 3 words 0xCC10_0080 (last on 3rd) -> writes addr 0..2, then zeros addr 3..31,
//   cpu_run=1 exactly 30 cycles after 3rd handshake's write cycle... i.e. after addr 31 write.
//  32 words, load_last never asserted -> no FILL; RUN entered cycle after addr 31 write.
//  load_valid toggled 1/0 each cycle -> writes only on handshake cycles, addresses contiguous.
//  RUN 40 cycles then halt_req -> done=1, run_cycles=40, cpu_run=0; start_load reloads cleanly.
//  CYCLE_LIMIT_EN, MAX_CYCLES=100, no halt_req -> timeout=1, done=1, run_cycles=100;
//   RESET asserted mid-LOAD -> immediate IDLE outputs, icache_we=0.

Source files
------------

// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: streams a program into the icache, zero-fills the rest, then runs/parks the core.
// Optional run-cycle watchdog enabled by defining CYCLE_LIMIT_EN.
module cpu_boot_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int MAX_CYCLES = 5000
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              start_load,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              icache_we,
  output logic [ADDR_W-1:0] icache_addr,
  output logic [DATA_W-1:0] icache_wdata,
  output logic              cpu_rst,
  output logic              cpu_run,
  input  logic              halt_req,
  output logic [31:0]       run_cycles,
  output logic              done,
  output logic              timeout
);
  typedef enum logic [2:0] {IDLE, LOAD, FILL, RUN, HALT} state_t;
`ifdef CYCLE_LIMIT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  state_t state, nxt;
  logic [ADDR_W:0] wp;
  logic hs, fill_wr, wd_hit;
  assign hs = state == LOAD && load_valid;
  // wp's top bit marks "every word written", so a full load enters FILL but writes nothing
  assign fill_wr = state == FILL && !wp[ADDR_W];
  assign wd_hit = WD_EN && run_cycles == 32'(MAX_CYCLES - 1);
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) state <= IDLE;
    else state <= nxt;
  // RUN starts the cycle after the final icache write is presented
  always_comb begin
    nxt = state;
    case (state)
      IDLE, HALT: nxt = start_load ? LOAD : state;
      LOAD:       nxt = hs && (load_last || wp[ADDR_W-1:0] == '1) ? FILL : LOAD;
      FILL:       nxt = icache_we && icache_addr == '1 ? RUN : FILL;
      RUN:        nxt = halt_req || wd_hit ? HALT : RUN;
      default:    nxt = IDLE;
    endcase
  end
  always_comb begin
    load_ready = state == LOAD;
    cpu_rst = state == IDLE || state == LOAD || state == FILL;
    cpu_run = state == RUN;
    done = state == HALT;
  end
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) begin
      wp <= '0;
      icache_we <= 1'b0;
      icache_addr <= '0;
      icache_wdata <= '0;
      run_cycles <= '0;
    end else begin
      icache_we <= hs || fill_wr;
      if (hs || fill_wr) begin
        icache_addr <= wp[ADDR_W-1:0];
        icache_wdata <= hs ? load_data : '0;
      end
      wp <= (state != LOAD && nxt == LOAD) ? '0 : (hs || fill_wr) ? wp + 1'b1 : wp;
      run_cycles <= (state != RUN && nxt == RUN) ? '0 :
                    (state == RUN && ~&run_cycles) ? run_cycles + 1 : run_cycles;
    end
`ifdef CYCLE_LIMIT_EN
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) timeout <= 1'b0;
    else if (state == RUN && nxt == HALT) timeout <= !halt_req;
    else if (state == HALT && start_load) timeout <= 1'b0;
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// tb_cpu_boot_ctrl: randomized load/run/halt sequences with a write scoreboard.
module tb_cpu_boot_ctrl;
  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  logic clk = 0, rst = 1;
  logic start_load = 0, load_valid = 0, load_last = 0, halt_req = 0;
  logic [31:0] load_data = 0;
  logic load_ready, icache_we, cpu_rst, cpu_run, done, timeout;
  logic [4:0] icache_addr;
  logic [31:0] icache_wdata, run_cycles;
  int cyc = 0, checks = 0, errors = 0, w31 = -100;
  wr_t exp_q[$];

  cpu_boot_ctrl #(.ADDR_W(5), .DATA_W(32), .MAX_CYCLES(100)) dut (
    .CLOCK_50(clk), .RESET(rst), .start_load(start_load), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .icache_we(icache_we), .icache_addr(icache_addr), .icache_wdata(icache_wdata),
    .cpu_rst(cpu_rst), .cpu_run(cpu_run), .halt_req(halt_req), .run_cycles(run_cycles),
    .done(done), .timeout(timeout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: every presented icache write must be the next expected one
  always @(negedge clk) begin : mon
    wr_t e;
    if (icache_we === 1'b1) begin
      chk("we_while_core_reset", cpu_rst, 1);
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", icache_addr, e.a);
        chk("wr_data", icache_wdata, e.d);
        if (icache_addr == 5'd31) w31 = cyc;
      end
    end
  end

  task automatic load_prog(input int n, input bit use_last, input bit toggle, input bit fixed);
    logic [31:0] d[32];
    int i = 0, g = 0;
    bit hs;
    for (int j = 0; j < 32; j++) begin
      d[j] = fixed ? 32'hCC10_0080 : $urandom;
      exp_q.push_back('{a: 5'(j), d: (j < n) ? d[j] : 32'h0});
    end
    @(posedge clk); #1 start_load = 1;
    @(posedge clk); #1 start_load = 0;
    @(negedge clk);
    chk("enter_cpu_rst", cpu_rst, 1);
    chk("enter_done", done, 0);
    chk("enter_timeout", timeout, 0);
    chk("enter_ready", load_ready, 1);
    @(posedge clk); #1;
    while (i < n && g < 500) begin
      load_valid = toggle ? (g % 2 == 0) : ($urandom_range(3) != 0);
      load_data = load_valid ? d[i] : $urandom;
      load_last = load_valid && use_last && i == n - 1;
      @(negedge clk); hs = load_valid && load_ready;
      @(posedge clk); #1;
      if (hs) i++;
      g++;
    end
    if (i < n) chk("load_budget", i, n);
    load_valid = 1; load_last = 0; load_data = $urandom;
    @(negedge clk);
    chk("ready_drop", load_ready, 0);
    g = 0;
    while (!cpu_run && g < 60) begin @(negedge clk); g++; end
    load_valid = 0;
    chk("run_entry_cycle", cyc, w31 + 1);
    chk("run_cpu_rst", cpu_rst, 0);
    chk("run_cycles_cleared", run_cycles, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  // called at a negedge inside the first RUN cycle; halts during RUN cycle k
  task automatic run_halt(input int k);
    for (int j = 1; j < k; j++) begin
      start_load = (j == 2);
      @(posedge clk); #1;
    end
    start_load = 0; halt_req = 1;
    @(posedge clk); #1 halt_req = 0;
    @(negedge clk);
    chk("halt_done", done, 1);
    chk("halt_cpu_run", cpu_run, 0);
    chk("halt_cpu_rst", cpu_rst, 0);
    chk("halt_run_cycles", run_cycles, k);
    chk("halt_timeout", timeout, 0);
    halt_req = 1;
    @(posedge clk); #1 halt_req = 0;
    @(negedge clk);
    chk("halt_hold_done", done, 1);
    chk("halt_hold_cycles", run_cycles, k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (5) begin
      @(negedge clk);
      chk("idle_cpu_rst", cpu_rst, 1);
      chk("idle_cpu_run", cpu_run, 0);
      chk("idle_done", done, 0);
      chk("idle_we", icache_we, 0);
    end
    load_prog(3, 1, 0, 1);
    run_halt(40);
    load_prog(32, 0, 0, 0);
    run_halt($urandom_range(99, 1));
    load_prog($urandom_range(31, 2), 1, 1, 0);
    run_halt(1);
    repeat (5) begin
      n = $urandom_range(32, 1);
      load_prog(n, n < 32 ? 1'b1 : 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
      run_halt($urandom_range(99, 1));
    end
`ifdef CYCLE_LIMIT_EN
    begin
      int g = 0;
      load_prog(5, 1, 0, 0);
      while (!done && g < 300) begin @(negedge clk); g++; end
      chk("wd_done", done, 1);
      chk("wd_timeout", timeout, 1);
      chk("wd_run_cycles", run_cycles, 100);
      chk("wd_cpu_run", cpu_run, 0);
    end
`endif
    @(posedge clk); #1 start_load = 1;
    @(posedge clk); #1 start_load = 0; load_valid = 1; load_data = 32'hA0;
    exp_q.push_back('{a: 5'd0, d: 32'hA0});
    exp_q.push_back('{a: 5'd1, d: 32'hA1});
    @(posedge clk); #1 load_data = 32'hA1;
    @(posedge clk); #1 load_data = 32'hA2;
    @(posedge clk); #3 rst = 1;
    #1;
    chk("rst_we", icache_we, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_scoreboard", exp_q.size(), 0);
    exp_q.delete();
    load_valid = 0;
    @(posedge clk); #1 rst = 0;
    load_prog(7, 1, 0, 0);
    run_halt(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
